// File: rtl/ccs_exec_unit_if.sv
// ccs_exec_unit_if: command, memory-read and result bundle for the CCS execution unit.
interface ccs_exec_unit_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pcIn;
    logic              busy;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memAck;
    logic [WIDTH-1:0]  memData;
    logic [WIDTH-1:0]  aOut;
    logic              aWe;
    logic [ADDR_W-1:0] pcOut;
    logic              pcWe;
    logic [1:0]        ccsClass;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  cntPos;
    logic [CNT_W-1:0]  cntPz;
    logic [CNT_W-1:0]  cntNeg;
    logic [CNT_W-1:0]  cntNz;
    modport master (
        output start, addr, pcIn, memAck, memData,
        input  busy, memReq, memAddr, aOut, aWe, pcOut, pcWe, ccsClass, done, err,
               cntPos, cntPz, cntNeg, cntNz
    );
    modport slave (
        input  start, addr, pcIn, memAck, memData,
        output busy, memReq, memAddr, aOut, aWe, pcOut, pcWe, ccsClass, done, err,
               cntPos, cntPz, cntNeg, cntNz
    );
endinterface

// File: rtl/ccs_exec_unit.sv
// ccs_exec_unit: multi-cycle CCS (count, compare, skip) with operand fetch, timeout and class counters.
module ccs_exec_unit #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    ccs_exec_unit_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    typedef enum logic [1:0] {IDLE, REQ, EXEC, WB} state_t;
    state_t            state_q;
    logic [TW-1:0]     wait_q;
    logic [WIDTH-1:0]  data_q, a_q, a_d;
    logic [ADDR_W-1:0] addr_q, pcin_q, pc_q, pc_d;
    logic [1:0]        class_q, class_d;
    logic              req_q, we_q, done_q, err_q, tout_q, zero, ones;
    logic [CNT_W-1:0]  cnt_q [4];
    always_comb begin
        zero    = data_q == '0;
        ones    = &data_q;
        class_d = zero ? 2'd1 : ones ? 2'd3 : data_q[WIDTH-1] ? 2'd2 : 2'd0;
        a_d     = (zero || ones) ? '0 : data_q[WIDTH-1] ? ~data_q - ONE : data_q - ONE;
        pc_d    = pcin_q + ADDR_W'(1) + ADDR_W'(class_d);
    end
    // WB spans two cycles: the first raises the strobes, the second drops them together with busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            data_q  <= '0;
            a_q     <= '0;
            addr_q  <= '0;
            pcin_q  <= '0;
            pc_q    <= '0;
            class_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= bus.addr;
                    pcin_q  <= bus.pcIn;
                    wait_q  <= '0;
                    tout_q  <= 1'b0;
                end
                REQ: if (bus.memAck) begin
                    data_q  <= bus.memData;
                    req_q   <= 1'b0;
                    state_q <= EXEC;
                end else if (wait_q == LAST) begin
                    req_q   <= 1'b0;
                    tout_q  <= 1'b1;
                    state_q <= WB;
                end else begin
                    wait_q <= wait_q + TW'(1);
                end
                EXEC: begin
                    a_q     <= a_d;
                    pc_q    <= pc_d;
                    class_q <= class_d;
                    state_q <= WB;
                end
                WB: if (!done_q) begin
                    done_q <= 1'b1;
                    err_q  <= tout_q;
                    we_q   <= !tout_q;
                    if (!tout_q && cnt_q[class_q] != '1) cnt_q[class_q] <= cnt_q[class_q] + CNT_W'(1);
                end else begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus.busy     = state_q != IDLE;
    assign bus.memReq   = req_q;
    assign bus.memAddr  = addr_q;
    assign bus.aOut     = a_q;
    assign bus.aWe      = we_q;
    assign bus.pcOut    = pc_q;
    assign bus.pcWe     = we_q;
    assign bus.ccsClass = class_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cntPos   = cnt_q[0];
    assign bus.cntPz    = cnt_q[1];
    assign bus.cntNeg   = cnt_q[2];
    assign bus.cntNz    = cnt_q[3];
endmodule
